// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter that feeds a single UART transmitter.
// Optional WAIT_BUSY watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int SEND_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  uart_tx_data,
  output logic        uart_send_data,
  input  logic        uart_tx_busy,
  output logic [1:0]  active_id,
  output logic        arb_busy,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] ack_q, ack_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       send_q, send_d;
  logic [1:0] active_id_q, active_id_d;
  logic [3:0] send_cnt_q, send_cnt_d;
  logic       arb_busy_q, arb_busy_d;
  logic       timeout_err_d;

  logic       grant_found;
  logic [1:0] grant_id;
  logic [1:0] idx;

  // Round-robin search: first requester at or after rr_ptr, wrapping mod 4.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr_q;
    idx         = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] timeout_cnt_q, timeout_cnt_d;
  logic        timeout_err_q;
`else
  // Keeps the watchdog parameter referenced when the counter is compiled out.
  logic timeout_cycles_unused;
  assign timeout_cycles_unused = |16'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    ack_d         = 4'b0000;
    tx_data_d     = tx_data_q;
    send_d        = send_q;
    active_id_d   = active_id_q;
    send_cnt_d    = send_cnt_q;
    timeout_err_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_cnt_d = 16'd0;
`endif
    case (state_q)
      IDLE: begin
        // A foreign transmission (busy while idle) blocks every grant.
        if (grant_found && !uart_tx_busy) begin
          state_d     = LAUNCH;
          ack_d       = 4'b0001 << grant_id;
          tx_data_d   = req_data[{grant_id, 3'b000} +: 8];
          active_id_d = grant_id;
          send_d      = 1'b1;
          send_cnt_d  = 4'd1;
          rr_ptr_d    = grant_id + 2'd1;
        end
      end
      LAUNCH: begin
        if (send_cnt_q >= 4'(SEND_CYCLES)) begin
          send_d  = 1'b0;
          state_d = uart_tx_busy ? WAIT_DONE : WAIT_BUSY;
        end else begin
          send_cnt_d = send_cnt_q + 4'd1;
        end
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
          if (timeout_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end else begin
            timeout_cnt_d = timeout_cnt_q + 16'd1;
          end
`endif
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  // NOTE: the async reset clears every flop, including the captured byte, so
  // an aborted transfer leaves nothing to replay.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      ack_q       <= 4'b0000;
      tx_data_q   <= 8'h00;
      send_q      <= 1'b0;
      active_id_q <= 2'd0;
      send_cnt_q  <= 4'd0;
      arb_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_q       <= ack_d;
      tx_data_q   <= tx_data_d;
      send_q      <= send_d;
      active_id_q <= active_id_d;
      send_cnt_q  <= send_cnt_d;
      arb_busy_q  <= arb_busy_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      timeout_cnt_q <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  logic timeout_err_d_unused;
  assign timeout_err_d_unused = timeout_err_d;
  assign timeout_err          = 1'b0;
`endif

  assign ack            = ack_q;
  assign uart_tx_data   = tx_data_q;
  assign uart_send_data = send_q;
  assign active_id      = active_id_q;
  assign arb_busy       = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the UART busy line is
// driven by hand. Define UART_ARB_TIMEOUT_EN to exercise the watchdog build.
module tb_uart_tx_arbiter;

  localparam int SEND_CYCLES    = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b0;
  logic [3:0]  req     = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic        uart_tx_busy = 1'b0;
  logic [3:0]  ack;
  logic [7:0]  uart_tx_data;
  logic        uart_send_data;
  logic [1:0]  active_id;
  logic        arb_busy;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(
    .SEND_CYCLES   (SEND_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .uart_tx_data  (uart_tx_data),
    .uart_send_data(uart_send_data),
    .uart_tx_busy  (uart_tx_busy),
    .active_id     (active_id),
    .arb_busy      (arb_busy),
    .timeout_err   (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ack"},       32'(ack),            32'h0);
    check({tag, ".tx_data"},   32'(uart_tx_data),   32'h0);
    check({tag, ".send"},      32'(uart_send_data), 32'h0);
    check({tag, ".active_id"}, 32'(active_id),      32'h0);
    check({tag, ".arb_busy"},  32'(arb_busy),       32'h0);
    check({tag, ".timeout"},   32'(timeout_err),    32'h0);
  endtask

  // One full transfer: grant one cycle after entry, send strobe for two
  // cycles, then busy high for four cycles and back to idle.
  task automatic do_xfer(input string tag, input logic [3:0] exp_ack, input logic [7:0] exp_byte,
                         input logic [1:0] exp_id, input logic [3:0] clear, input bit scramble);
    int waits = 0;
    while (ack === 4'b0000 && waits < 20) begin
      tick();
      waits++;
    end
    check({tag, ".wait"},      32'(waits),          32'd1);
    check({tag, ".ack"},       32'(ack),            32'(exp_ack));
    check({tag, ".tx_data"},   32'(uart_tx_data),   32'(exp_byte));
    check({tag, ".active_id"}, 32'(active_id),      32'(exp_id));
    check({tag, ".send1"},     32'(uart_send_data), 32'd1);
    check({tag, ".arb_busy"},  32'(arb_busy),       32'd1);
    req = req & ~clear;
    if (scramble) req_data = ~req_data;
    tick();
    check({tag, ".ack_off"},   32'(ack),            32'h0);
    check({tag, ".send2"},     32'(uart_send_data), 32'd1);
    tick();
    check({tag, ".send_off"},  32'(uart_send_data), 32'd0);
    check({tag, ".wait_busy"}, 32'(arb_busy),       32'd1);
    uart_tx_busy = 1'b1;
    repeat (4) tick();
    check({tag, ".hold_byte"}, 32'(uart_tx_data),   32'(exp_byte));
    check({tag, ".wait_done"}, 32'(arb_busy),       32'd1);
    uart_tx_busy = 1'b0;
    tick();
    check({tag, ".idle"},      32'(arb_busy),       32'd0);
  endtask

  initial begin
    // Reset: requests present while in reset must not be acknowledged.
    req = 4'b1111;
    repeat (2) tick();
    check_reset_values("reset");

    // Contention: all four held, pointer starts at 0.
    req_data = 32'h4433_2211;
    reset    = 1'b1;
    do_xfer("rr0", 4'b0001, 8'h11, 2'd0, 4'b0000, 1'b0);
    do_xfer("rr1", 4'b0010, 8'h22, 2'd1, 4'b0000, 1'b0);
    do_xfer("rr2", 4'b0100, 8'h33, 2'd2, 4'b0000, 1'b0);
    do_xfer("rr3", 4'b1000, 8'h44, 2'd3, 4'b0000, 1'b0);
    do_xfer("rr4", 4'b0001, 8'h11, 2'd0, 4'b1111, 1'b0);

    // Single requester; data changed after capture must not leak through.
    req_data = 32'h00A5_0000;
    req      = 4'b0100;
    do_xfer("single", 4'b0100, 8'hA5, 2'd2, 4'b0100, 1'b1);

    // Foreign busy in IDLE blocks the grant until it falls.
    req_data     = 32'h0000_00BE;
    uart_tx_busy = 1'b1;
    req          = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("foreign.ack",  32'(ack),            32'h0);
      check("foreign.send", 32'(uart_send_data), 32'h0);
    end
    uart_tx_busy = 1'b0;
    do_xfer("foreign", 4'b0001, 8'hBE, 2'd0, 4'b0001, 1'b0);

    // Reset in WAIT_DONE: outputs clear immediately, pointer back to 0.
    req_data = 32'h003C_0000;
    req      = 4'b0100;
    tick();
    check("midop.ack", 32'(ack), 32'(4'b0100));
    req = 4'b0000;
    repeat (2) tick();
    uart_tx_busy = 1'b1;
    tick();
    check("midop.in_wait_done", 32'(arb_busy), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_values("midop_reset");
    tick();
    uart_tx_busy = 1'b0;
    req_data     = 32'h7700_5500;
    req          = 4'b1010;
    reset        = 1'b1;
    do_xfer("rst_release", 4'b0010, 8'h55, 2'd1, 4'b0010, 1'b0);

    // Watchdog: requester 3 is granted, busy never rises.
    tick();
    check("to.ack",     32'(ack),          32'(4'b1000));
    check("to.tx_data", 32'(uart_tx_data), 32'h77);
    req = 4'b0000;
    repeat (2) tick();
    check("to.send_off", 32'(uart_send_data), 32'd0);
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      tick();
`ifdef UART_ARB_TIMEOUT_EN
      if (k < TIMEOUT_CYCLES) begin
        check("to.quiet",    32'(timeout_err), 32'd0);
        check("to.waiting",  32'(arb_busy),    32'd1);
      end else begin
        check("to.pulse",    32'(timeout_err), 32'd1);
        check("to.idle",     32'(arb_busy),    32'd0);
      end
`else
      check("to.never",   32'(timeout_err), 32'd0);
      check("to.waiting", 32'(arb_busy),    32'd1);
`endif
    end
    tick();
    check("to.pulse_off", 32'(timeout_err), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    check("to.stay_idle", 32'(arb_busy), 32'd0);
`else
    check("to.still_wait", 32'(arb_busy), 32'd1);
    uart_tx_busy = 1'b1;
    tick();
    uart_tx_busy = 1'b0;
    tick();
    check("to.released", 32'(arb_busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
